// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: shared definitions for the ALU issue queue.
//   - op encodings driven on alu_op
//   - FSM state type
//   - packed command record stored in the command FIFO
// Build option: ALU_ISSUE_TAG_EN adds a 3-bit sequence tag to the record.
package alu_issue_pkg;

   localparam logic [1:0] OP_SRA = 2'b00;
   localparam logic [1:0] OP_SRL = 2'b01;
   localparam logic [1:0] OP_SUB = 2'b10;
   localparam logic [1:0] OP_ADD = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      HOLD = 2'd2
   } state_t;

`ifdef ALU_ISSUE_TAG_EN
   localparam int CMD_W = 15;
   typedef struct packed {
      logic [2:0] tag;
      logic [1:0] op;
      logic [1:0] c;
      logic [3:0] b;
      logic [3:0] a;
   } cmd_t;
`else
   localparam int CMD_W = 12;
   typedef struct packed {
      logic [1:0] op;
      logic [1:0] c;
      logic [3:0] b;
      logic [3:0] a;
   } cmd_t;
`endif

endpackage

// File: rtl/alu_issue_fifo.sv
// alu_issue_fifo: generic synchronous FIFO, show-ahead read (dout is the head).
// Ports:
//   clk, rst_n     clock, async active-low reset (clears pointers only)
//   push, din      write request/data; ignored while full
//   pop            read request; ignored while empty
//   dout           current head entry
//   full, empty    status from pointers with an extra wrap bit
module alu_issue_fifo #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2,
   parameter int W     = 12
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   logic [W-1:0] mem_q [DEPTH];
   logic [W-1:0] mem_d [DEPTH];
   logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
   logic do_push, do_pop;

   // Same index with differing wrap bit means the writer lapped the reader.
   assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                    (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem_q[rd_ptr_q[PTR_W-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      mem_d    = mem_q;
      if (do_push) begin
         mem_d[wr_ptr_q[PTR_W-1:0]] = din;
         wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, 1'b1};
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset; the pointers define what is valid.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/alu_issue_queue.sv
// alu_issue_queue: buffers ALU commands, issues them one at a time on
// registered alu_* outputs, captures alu_ans and returns it over a
// valid/ready result handshake.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   cmd_valid/cmd_ready, cmd_a/b/c/op  command input handshake
//   alu_a/b/c/op, alu_ans              registered operands out, ALU result in
//   res_valid/res_ready, res_data      result output handshake
//   busy                               FSM not IDLE or FIFO non-empty
//   res_tag                            (ALU_ISSUE_TAG_EN only) push-order tag
// Build option: ALU_ISSUE_TAG_EN.
//
// state | meaning
// IDLE  | no command in flight; pop head when FIFO non-empty
// EXEC  | alu_* stable, capture alu_ans into res_data
// HOLD  | res_valid high, wait for res_ready; pop next if available
module alu_issue_queue
   import alu_issue_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [3:0] cmd_a,
   input  logic [3:0] cmd_b,
   input  logic [1:0] cmd_c,
   input  logic [1:0] cmd_op,
   output logic [3:0] alu_a,
   output logic [3:0] alu_b,
   output logic [1:0] alu_c,
   output logic [1:0] alu_op,
   input  logic [3:0] alu_ans,
   output logic       res_valid,
   input  logic       res_ready,
   output logic [3:0] res_data,
   output logic       busy
`ifdef ALU_ISSUE_TAG_EN
   ,
   output logic [2:0] res_tag
`endif
);

   state_t     state_q, state_d;
   cmd_t       issue_q, issue_d;
   cmd_t       push_cmd, head;
   logic       res_valid_q, res_valid_d;
   logic [3:0] res_data_q, res_data_d;
   logic       fifo_full, fifo_empty, pop;

`ifdef ALU_ISSUE_TAG_EN
   logic [2:0] tag_cnt_q, tag_cnt_d;

   assign push_cmd = '{tag: tag_cnt_q, op: cmd_op, c: cmd_c, b: cmd_b, a: cmd_a};
   assign res_tag  = issue_q.tag;

   always_comb begin
      tag_cnt_d = tag_cnt_q;
      if (cmd_valid && cmd_ready) tag_cnt_d = tag_cnt_q + 3'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tag_cnt_q <= '0;
      else        tag_cnt_q <= tag_cnt_d;
   end
`else
   assign push_cmd = '{op: cmd_op, c: cmd_c, b: cmd_b, a: cmd_a};
`endif

   alu_issue_fifo #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W),
      .W     (CMD_W)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (cmd_valid),
      .din   (push_cmd),
      .pop   (pop),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Ready is the pre-pop view: a full FIFO refuses even when popping.
   assign cmd_ready = !fifo_full;
   assign alu_a     = issue_q.a;
   assign alu_b     = issue_q.b;
   assign alu_c     = issue_q.c;
   assign alu_op    = issue_q.op;
   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign busy      = (state_q != IDLE) || !fifo_empty;

   always_comb begin
      state_d     = state_q;
      issue_d     = issue_q;
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      pop         = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               issue_d = head;
               state_d = EXEC;
            end
         end
         EXEC: begin
            res_data_d  = alu_ans;
            res_valid_d = 1'b1;
            state_d     = HOLD;
         end
         HOLD: begin
            if (res_ready) begin
               res_valid_d = 1'b0;
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  issue_d = head;
                  state_d = EXEC;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         issue_q     <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         issue_q     <= issue_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
      end
   end

endmodule

// File: tb/tb_alu_issue_queue.sv
module tb_alu_issue_queue;
   import alu_issue_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_valid, cmd_ready;
   logic [3:0] cmd_a, cmd_b;
   logic [1:0] cmd_c, cmd_op;
   logic [3:0] alu_a, alu_b, alu_ans;
   logic [1:0] alu_c, alu_op;
   logic       res_valid, res_ready;
   logic [3:0] res_data;
   logic       busy;
`ifdef ALU_ISSUE_TAG_EN
   logic [2:0] res_tag;
`endif

   int checks = 0;
   int errors = 0;

   logic [3:0] got_data[$];
   logic [2:0] got_tag[$];

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic [1:0] c;
      logic [1:0] op;
      logic [3:0] exp;
   } vec_t;

   vec_t tbl[12];
   vec_t bp[6];

   always #5 clk = ~clk;

   function automatic logic [3:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                        input logic [1:0] c, input logic [1:0] op);
      logic [3:0] r;
      case (op)
         OP_SRA:  r = $signed(a) >>> c;
         OP_SRL:  r = a >> c;
         OP_SUB:  r = a - b;
         default: r = a + b;
      endcase
      return r;
   endfunction

   assign alu_ans = alu_f(alu_a, alu_b, alu_c, alu_op);

   alu_issue_queue #(.DEPTH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_a     (cmd_a),
      .cmd_b     (cmd_b),
      .cmd_c     (cmd_c),
      .cmd_op    (cmd_op),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_c     (alu_c),
      .alu_op    (alu_op),
      .alu_ans   (alu_ans),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .busy      (busy)
`ifdef ALU_ISSUE_TAG_EN
      ,
      .res_tag   (res_tag)
`endif
   );

   // Records every result that the next rising edge will consume.
   initial forever begin
      @(negedge clk);
      #1;
      if (rst_n && res_valid && res_ready) begin
         got_data.push_back(res_data);
`ifdef ALU_ISSUE_TAG_EN
         got_tag.push_back(res_tag);
`else
         got_tag.push_back(3'd0);
`endif
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send(input logic [3:0] a, input logic [3:0] b,
                       input logic [1:0] c, input logic [1:0] op);
      int n;
      n = 0;
      cmd_valid = 1'b1;
      cmd_a = a; cmd_b = b; cmd_c = c; cmd_op = op;
      while (!cmd_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) chk("send_timeout", 0, 1);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_valid(input string name);
      int n;
      n = 0;
      while (!res_valid && n < 10) begin
         @(negedge clk);
         n++;
      end
      if (!res_valid) chk(name, 0, 1);
   endtask

   task automatic wait_results(input int cnt, input string name);
      int n;
      n = 0;
      while (got_data.size() < cnt && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk(name, got_data.size(), cnt);
   endtask

   initial begin
      tbl[0]  = '{4'd3,  4'd4, 2'd0, OP_ADD, 4'd7};
      tbl[1]  = '{4'd8,  4'd0, 2'd2, OP_SRA, 4'd14};
      tbl[2]  = '{4'd8,  4'd0, 2'd2, OP_SRL, 4'd2};
      tbl[3]  = '{4'd5,  4'd7, 2'd0, OP_SUB, 4'd14};
      tbl[4]  = '{4'd15, 4'd1, 2'd0, OP_ADD, 4'd0};
      tbl[5]  = '{4'd7,  4'd0, 2'd3, OP_SRA, 4'd0};
      tbl[6]  = '{4'd15, 4'd0, 2'd1, OP_SRA, 4'd15};
      tbl[7]  = '{4'd9,  4'd0, 2'd3, OP_SRL, 4'd1};
      tbl[8]  = '{4'd0,  4'd1, 2'd0, OP_SUB, 4'd15};
      tbl[9]  = '{4'd10, 4'd3, 2'd0, OP_SRL, 4'd10};
      tbl[10] = '{4'd12, 4'd5, 2'd1, OP_SUB, 4'd7};
      tbl[11] = '{4'd6,  4'd9, 2'd0, OP_ADD, 4'd15};

      bp[0] = '{4'd1,  4'd2, 2'd0, OP_ADD, 4'd3};
      bp[1] = '{4'd9,  4'd3, 2'd0, OP_SUB, 4'd6};
      bp[2] = '{4'd12, 4'd0, 2'd1, OP_SRA, 4'd14};
      bp[3] = '{4'd12, 4'd0, 2'd1, OP_SRL, 4'd6};
      bp[4] = '{4'd7,  4'd7, 2'd0, OP_ADD, 4'd14};
      bp[5] = '{4'd2,  4'd5, 2'd0, OP_SUB, 4'd13};

      rst_n = 1'b0; cmd_valid = 1'b0; res_ready = 1'b0;
      cmd_a = '0; cmd_b = '0; cmd_c = '0; cmd_op = '0;
      repeat (2) @(negedge clk);
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_data",  res_data, 0);
      chk("rst_busy",      busy, 0);
      chk("rst_alu_a",     alu_a, 0);
      chk("rst_alu_op",    alu_op, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Single add: latency and busy
      res_ready = 1'b1;
      send(4'd3, 4'd4, 2'd0, OP_ADD);
      chk("lat_c1_valid", res_valid, 0);
      chk("lat_c1_busy",  busy, 1);
      @(negedge clk);
      chk("lat_c2_alu_a",  alu_a, 3);
      chk("lat_c2_alu_b",  alu_b, 4);
      chk("lat_c2_alu_op", alu_op, 3);
      chk("lat_c2_valid",  res_valid, 0);
      @(negedge clk);
      chk("lat_c3_valid", res_valid, 1);
      chk("lat_c3_data",  res_data, 7);
      @(negedge clk);
      chk("lat_c4_valid", res_valid, 0);
      chk("lat_c4_busy",  busy, 0);

      // Table of single commands
      for (int i = 0; i < 12; i++) begin
         send(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].op);
         wait_valid($sformatf("tbl%0d_valid", i));
         chk($sformatf("tbl%0d_data", i),  res_data, tbl[i].exp);
         chk($sformatf("tbl%0d_alu_a", i), alu_a, tbl[i].a);
         chk($sformatf("tbl%0d_alu_c", i), alu_c, tbl[i].c);
         chk($sformatf("tbl%0d_alu_op", i), alu_op, tbl[i].op);
         @(negedge clk);
      end
      repeat (2) @(negedge clk);

      // Backpressure: fill FIFO plus one in flight
      res_ready = 1'b0;
      got_data.delete();
      begin
         int idx;
         idx = 0;
         for (int cyc = 0; cyc < 8; cyc++) begin
            if (idx < 5) begin
               cmd_valid = 1'b1;
               cmd_a = bp[idx].a; cmd_b = bp[idx].b;
               cmd_c = bp[idx].c; cmd_op = bp[idx].op;
            end else begin
               cmd_valid = 1'b0;
            end
            if (cmd_valid && cmd_ready) idx++;
            @(negedge clk);
         end
         cmd_valid = 1'b0;
         chk("bp_accepted_when_full", idx, 5);
      end
      chk("bp_cmd_ready_full", cmd_ready, 0);
      chk("bp_res_valid_held", res_valid, 1);
      chk("bp_res_data_held",  res_data, 3);
      chk("bp_no_results_yet", got_data.size(), 0);

      // Push while full and popping: refused this cycle, accepted next
      cmd_valid = 1'b1;
      cmd_a = bp[5].a; cmd_b = bp[5].b; cmd_c = bp[5].c; cmd_op = bp[5].op;
      res_ready = 1'b1;
      chk("full_pop_push_refused", cmd_ready, 0);
      @(negedge clk);
      chk("full_pop_push_next", cmd_ready, 1);
      @(negedge clk);
      cmd_valid = 1'b0;
      wait_results(6, "bp_result_count");
      for (int i = 0; i < 6; i++) begin
         if (i < got_data.size()) chk($sformatf("bp_order%0d", i), got_data[i], bp[i].exp);
      end
      repeat (3) @(negedge clk);
      chk("bp_result_no_dup", got_data.size(), 6);
      chk("bp_busy_after", busy, 0);

      // Reset while holding a result with two commands queued
      res_ready = 1'b0;
      send(4'd1, 4'd1, 2'd0, OP_ADD);
      send(4'd2, 4'd2, 2'd0, OP_ADD);
      send(4'd3, 4'd3, 2'd0, OP_ADD);
      wait_valid("mid_rst_hold");
      chk("mid_rst_busy_before", busy, 1);
      got_data.delete();
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid_now", res_valid, 0);
      chk("mid_rst_ready_now", cmd_ready, 1);
      chk("mid_rst_busy_now",  busy, 0);
      chk("mid_rst_alu_a_now", alu_a, 0);
      @(negedge clk);
      rst_n = 1'b1;
      res_ready = 1'b1;
      repeat (10) @(negedge clk);
      chk("mid_rst_no_results", got_data.size(), 0);
      chk("mid_rst_busy_after", busy, 0);
      chk("mid_rst_ready_after", cmd_ready, 1);

`ifdef ALU_ISSUE_TAG_EN
      got_data.delete();
      got_tag.delete();
      for (int i = 0; i < 9; i++) send(4'(i), 4'd1, 2'd0, OP_ADD);
      wait_results(9, "tag_result_count");
      for (int i = 0; i < 9; i++) begin
         if (i < got_tag.size()) chk($sformatf("tag_seq%0d", i), got_tag[i], i % 8);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule
